hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
//  Stall/flush controller for the 5-stage RISC-V pipeline; the counterpart of
//  the EX-stage operand bypass logic. It resolves the hazards that bypassing
//  cannot: load-use, taken branches and multi-cycle data-memory waits.
//  It drives the PC and pipeline-register write/flush enables from decode (ID),
//  execute (EX) and memory (MEM) stage state.
//  It keeps a memory-wait FSM with a timeout, plus saturating stall and flush
//  performance counters.
// PARAMETERS
//  MEM_TIMEOUT  default 15  max consecutive MEM_WAIT cycles before ERROR (>=1)
//  CNT_W        default 16  width of the perf counters stall_cycles/flush_events
// PORTS
//  clk           in   1      clock, all state updates on rising edge
//  arst          in   1      asynchronous reset, active-high
//  rs1_id        in   5      source register 1 of the instruction in ID
//  rs2_id        in   5      source register 2 of the instruction in ID
//  rd_ex         in   5      destination register of the instruction in EX
//  mem_read_ex   in   1      instruction in EX is a load
//  branch_taken  in   1      branch/jump resolved taken in EX this cycle
//  dmem_busy     in   1      data memory not ready for the access in MEM
//  pc_write      out  1      PC update enable
//  if_id_write   out  1      IF/ID register write enable
//  if_id_flush   out  1      IF/ID register clear (insert NOP)
//  id_ex_write   out  1      ID/EX register write enable
//  id_ex_flush   out  1      ID/EX register clear (insert bubble)
//  ex_mem_write  out  1      EX/MEM and MEM/WB write enable
//  timeout_err   out  1      sticky: memory wait exceeded MEM_TIMEOUT
//  stall_cycles  out  CNT_W  saturating count of cycles with pc_write==0
//  flush_events  out  CNT_W  saturating count of branch flushes
// BEHAVIOUR
//  - Control outputs are combinational from inputs and registered state.
//    Counters, wait_cnt and the FSM are registered.
//  - FSM states:
//    - RUN: normal operation.
//    - MEM_WAIT: pipeline frozen on a data-memory wait.
//    - ERROR: terminal state after a timeout.
//  - Reset (async, any time, including mid-wait):
//    - state=RUN, wait_cnt=0, timeout_err=0, both counters=0.
//    - With inputs idle, outputs read: all *_write=1, both *_flush=0.
//  - RUN, evaluated in priority order (first match wins):
//    1) dmem_busy=1 (freeze):
//       - All four *_write=0 and both *_flush=0 this cycle.
//       - Next state MEM_WAIT, wait_cnt<=1.
//    2) branch_taken=1:
//       - if_id_flush=1, id_ex_flush=1; all writes=1.
//       - flush_events++.
//       - A simultaneous load-use is ignored, because the ID instruction is squashed.
//    3) Load-use, i.e. mem_read_ex && rd_ex!=0 && (rd_ex==rs1_id || rd_ex==rs2_id):
//       - pc_write=0, if_id_write=0, id_ex_flush=1; id_ex_write=1, ex_mem_write=1.
//       - Exactly one bubble: the next cycle EX holds the bubble, so the hazard
//         clears on its own.
//    4) Otherwise: all writes=1, no flush.
//  - MEM_WAIT: all writes=0, no flushes; inputs branch_taken, rs*/rd are ignored.
//    - dmem_busy=0: go to RUN, wait_cnt<=0. The outputs in this cycle are still
//      frozen; the pipeline advances on the next cycle.
//    - dmem_busy=1 and wait_cnt==MEM_TIMEOUT: go to ERROR, timeout_err<=1.
//    - Else wait_cnt++.
//  - ERROR: all writes=0, no flushes, timeout_err=1. Left only by arst.
//  - stall_cycles increments in every cycle where pc_write==0, in any state.
//  - Both counters saturate at 2^CNT_W-1; they never wrap.
//  - rd_ex==0 never causes a stall. x0 is never a hazard.
// TESTING
//  T1 reset:
//    - arst=1 mid-MEM_WAIT (wait_cnt=5), released.
//    - Expect state RUN, counters 0, timeout_err=0, pc_write=1, flushes 0.
//  T2 load-use:
//    - mem_read_ex=1, rd_ex=5, rs2_id=5 for 1 cycle.
//    - Expect pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_cycles=1.
//  T3 x0 load:
//    - mem_read_ex=1, rd_ex=0, rs1_id=0.
//    - Expect no stall; all writes=1.
//  T4 branch plus load-use in the same cycle:
//    - Expect if_id_flush=1, id_ex_flush=1, pc_write=1; flush_events=1, stall_cycles=0.
//  T5 memory wait:
//    - dmem_busy high for 3 cycles, then low.
//    - Expect all writes=0 for 4 cycles, release on cycle 5, stall_cycles=4,
//      timeout_err=0.
//  T6 timeout:
//    - MEM_TIMEOUT=3, dmem_busy held high.
//    - Expect timeout_err=1 after the 4th busy cycle, sticky after dmem_busy
//      drops, cleared only by arst.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch flushes and a
// data-memory wait FSM with timeout, plus saturating stall/flush performance counters.
module hazard_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int unsigned WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

    state_e           state_q;
    logic [WW-1:0]    wait_q;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             load_use;
    logic             flush_evt;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    assign load_use  = mem_read_ex && (rd_ex != 5'd0) &&
                       ((rd_ex == rs1_id) || (rd_ex == rs2_id));
    assign flush_evt = (state_q == StRun) && !dmem_busy && branch_taken;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        case (state_q)
            StRun: begin
                if (dmem_busy) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                end else if (branch_taken) begin
                    // squashing ID also removes any load-use dependency it carried
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            default: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= StRun;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (dmem_busy) begin
                        state_q <= StMemWait;
                        wait_q  <= WW'(1);
                    end
                end
                StMemWait: begin
                    if (!dmem_busy) begin
                        state_q <= StRun;
                        wait_q  <= '0;
                    end else if (wait_q == WW'(MEM_TIMEOUT)) begin
                        state_q   <= StError;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                StError: timeout_q <= 1'b1;
                default: state_q <= StRun;
            endcase

            if (!pc_write && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_evt && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign timeout_err  = timeout_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: instance a uses the default timeout with 4-bit counters, instance b a
// 3-cycle timeout; both share the same stimulus.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       arst;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       mem_read_ex, branch_taken, dmem_busy;

    logic        a_pc, a_ifw, a_iff, a_idw, a_idf, a_exw, a_to;
    logic [3:0]  a_stall, a_flush;
    logic        b_pc, b_ifw, b_iff, b_idw, b_idf, b_exw, b_to;
    logic [15:0] b_stall, b_flush;

    logic [5:0] a_ctrl, b_ctrl;
    assign a_ctrl = {a_pc, a_ifw, a_iff, a_idw, a_idf, a_exw};
    assign b_ctrl = {b_pc, b_ifw, b_iff, b_idw, b_idf, b_exw};

    // {pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w}
    localparam logic [5:0] NORM = 6'b110101;
    localparam logic [5:0] LDU  = 6'b000111;
    localparam logic [5:0] BRF  = 6'b111111;
    localparam logic [5:0] FRZ  = 6'b000000;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.MEM_TIMEOUT(15), .CNT_W(4)) dut_a (
        .clk(clk), .arst(arst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_write(a_pc), .if_id_write(a_ifw), .if_id_flush(a_iff), .id_ex_write(a_idw),
        .id_ex_flush(a_idf), .ex_mem_write(a_exw), .timeout_err(a_to),
        .stall_cycles(a_stall), .flush_events(a_flush)
    );

    hazard_control_unit #(.MEM_TIMEOUT(3), .CNT_W(16)) dut_b (
        .clk(clk), .arst(arst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
        .mem_read_ex(mem_read_ex), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_write(b_pc), .if_id_write(b_ifw), .if_id_flush(b_iff), .id_ex_write(b_idw),
        .id_ex_flush(b_idf), .ex_mem_write(b_exw), .timeout_err(b_to),
        .stall_cycles(b_stall), .flush_events(b_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
        mem_read_ex = 1'b0; branch_taken = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        idle();
        arst = 1'b1;
        #12;
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("init_ctrl", 32'(a_ctrl), 32'(NORM));
        chk("init_stall", 32'(a_stall), 32'd0);

        // T1: reset in the middle of a memory wait (a: wait_cnt=5, b: already timed out)
        dmem_busy = 1'b1;
        cycles(5);
        chk("t1_pre_stall_a", 32'(a_stall), 32'd5);
        chk("t1_pre_to_b", 32'(b_to), 32'd1);
        dmem_busy = 1'b0;
        arst = 1'b1;
        #1;
        chk("t1_rst_stall_a", 32'(a_stall), 32'd0);
        chk("t1_rst_to_b", 32'(b_to), 32'd0);
        chk("t1_rst_ctrl_b", 32'(b_ctrl), 32'(NORM));
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        #1;
        chk("t1_ctrl_a", 32'(a_ctrl), 32'(NORM));
        chk("t1_stall_b", 32'(b_stall), 32'd0);
        chk("t1_flush_a", 32'(a_flush), 32'd0);

        // T2: load-use on rs2, then on rs1, then a non-load with matching rd
        mem_read_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; rs1_id = 5'd3;
        #1;
        chk("t2_ldu_rs2", 32'(a_ctrl), 32'(LDU));
        @(negedge clk);
        idle();
        #1;
        chk("t2_stall1", 32'(a_stall), 32'd1);
        chk("t2_after", 32'(a_ctrl), 32'(NORM));
        mem_read_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; rs2_id = 5'd2;
        #1;
        chk("t2_ldu_rs1", 32'(a_ctrl), 32'(LDU));
        @(negedge clk);
        mem_read_ex = 1'b0;
        #1;
        chk("t2_no_load", 32'(a_ctrl), 32'(NORM));
        @(negedge clk);
        chk("t2_stall2", 32'(a_stall), 32'd2);

        // T3: load to x0 with x0 sources never stalls
        idle();
        mem_read_ex = 1'b1;
        #1;
        chk("t3_x0", 32'(a_ctrl), 32'(NORM));
        @(negedge clk);
        chk("t3_stall", 32'(a_stall), 32'd2);

        // T4: taken branch wins over a simultaneous load-use
        branch_taken = 1'b1; mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5;
        #1;
        chk("t4_ctrl", 32'(a_ctrl), 32'(BRF));
        @(negedge clk);
        idle();
        #1;
        chk("t4_flush", 32'(a_flush), 32'd1);
        chk("t4_stall", 32'(a_stall), 32'd2);

        // T5: 3 busy cycles (branch on the first is overridden), released on cycle 5
        dmem_busy = 1'b1; branch_taken = 1'b1;
        #1;
        chk("t5_c1", 32'(a_ctrl), 32'(FRZ));
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        chk("t5_c2", 32'(a_ctrl), 32'(FRZ));
        @(negedge clk);
        #1;
        chk("t5_c3", 32'(a_ctrl), 32'(FRZ));
        @(negedge clk);
        dmem_busy = 1'b0; branch_taken = 1'b1;
        #1;
        chk("t5_c4_a", 32'(a_ctrl), 32'(FRZ));
        chk("t5_c4_b", 32'(b_ctrl), 32'(FRZ));
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        chk("t5_c5_a", 32'(a_ctrl), 32'(NORM));
        chk("t5_c5_b", 32'(b_ctrl), 32'(NORM));
        chk("t5_stall", 32'(a_stall), 32'd6);
        chk("t5_flush", 32'(a_flush), 32'd1);
        chk("t5_to_b", 32'(b_to), 32'd0);

        // T6: b times out on its 4th busy cycle and stays in error
        dmem_busy = 1'b1;
        cycles(3);
        chk("t6_to_b_3", 32'(b_to), 32'd0);
        cycles(1);
        chk("t6_to_b_4", 32'(b_to), 32'd1);
        cycles(2);
        chk("t6_to_a", 32'(a_to), 32'd0);
        dmem_busy = 1'b0;
        #1;
        chk("t6_rel_a", 32'(a_ctrl), 32'(FRZ));
        @(negedge clk);
        branch_taken = 1'b1;
        #1;
        chk("t6_run_a", 32'(a_ctrl), 32'(BRF));
        chk("t6_err_b", 32'(b_ctrl), 32'(FRZ));
        chk("t6_sticky_b", 32'(b_to), 32'd1);
        chk("t6_stall_a", 32'(a_stall), 32'd13);
        @(negedge clk);
        chk("t6_flush_a", 32'(a_flush), 32'd2);

        // Saturation of the 4-bit counters in a
        idle();
        mem_read_ex = 1'b1; rd_ex = 5'd9; rs2_id = 5'd9;
        cycles(2);
        chk("sat_stall_15", 32'(a_stall), 32'd15);
        cycles(2);
        chk("sat_stall_hold", 32'(a_stall), 32'd15);
        idle();
        branch_taken = 1'b1;
        cycles(12);
        chk("sat_flush_14", 32'(a_flush), 32'd14);
        cycles(3);
        chk("sat_flush_hold", 32'(a_flush), 32'd15);
        idle();

        // Only arst leaves the error state
        chk("err_before_rst", 32'(b_to), 32'd1);
        arst = 1'b1;
        #1;
        chk("err_cleared", 32'(b_to), 32'd0);
        chk("err_ctrl", 32'(b_ctrl), 32'(NORM));
        @(negedge clk);
        arst = 1'b0;
        cycles(2);
        chk("final_stall_b", 32'(b_stall), 32'd0);
        chk("final_to_b", 32'(b_to), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
